// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: access-size encodings, FSM states,
// the captured request control word and a lane-count helper.
package mem_pkg;

  typedef enum logic [1:0] {
    MT_WORD  = 2'b00,
    MT_HALF  = 2'b01,
    MT_BYTE  = 2'b10,
    MT_DWORD = 2'b11
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Control bits latched when an access is accepted; held for the whole transaction.
  typedef struct packed {
    logic      we;
    mem_type_e mtype;
    logic      sext;
  } req_ctl_t;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: alignment check, store byte enables and lane-replicated
// store data, and load byte-lane extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = lane_count(DATA_W),
  parameter int LB     = $clog2(LANES)
) (
  input  mem_type_e              st_type,
  input  logic [2:0]             st_addr_lo,
  input  logic [DATA_W-1:0]      st_wdata,
  output logic                   misalign,
  output logic [LANES-1:0]       st_be,
  output logic [DATA_W-1:0]      st_wdata_rep,
  input  mem_type_e              ld_type,
  input  logic                   ld_sext,
  input  logic [LB-1:0]          ld_lane,
  input  logic [DATA_W-1:0]      ld_rdata,
  output logic [DATA_W-1:0]      ld_data
);

  logic [LB-1:0]           st_lane;
  logic [LANES-1:0][7:0]   rep;
  logic [DATA_W-1:0]       sh;
  logic [DATA_W-1:0]       word_ext;

  assign st_lane = st_addr_lo[LB-1:0];

  // Alignment check and byte enables; dword is only legal on a 64-bit bus.
  always_comb begin
    misalign = 1'b0;
    st_be    = '1;
    case (st_type)
      MT_BYTE:  st_be = LANES'(1) << st_lane;
      MT_HALF: begin
        misalign = st_addr_lo[0];
        st_be    = LANES'(2'b11) << st_lane;
      end
      MT_WORD: begin
        misalign = |st_addr_lo[1:0];
        st_be    = LANES'(4'hF) << st_lane;
      end
      default: begin
        misalign = (DATA_W != 64) || (|st_addr_lo);
        st_be    = '1;
      end
    endcase
  end

  // Each lane repeats the low bytes of the store data at the access size.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign rep[i] = (st_type == MT_BYTE) ? st_wdata[7:0] :
                    (st_type == MT_HALF) ? st_wdata[(i%2)*8 +: 8] :
                    (st_type == MT_WORD) ? st_wdata[(i%4)*8 +: 8] :
                                           st_wdata[i*8 +: 8];
  end
  assign st_wdata_rep = rep;

  assign sh = ld_rdata >> {ld_lane, 3'b000};

  if (DATA_W == 64) begin : g_w64
    assign word_ext = {{(DATA_W-32){ld_sext & sh[31]}}, sh[31:0]};
  end else begin : g_w32
    assign word_ext = sh;
  end

  // Load data: selected lane already at bit 0, extend to the full bus width.
  always_comb begin
    case (ld_type)
      MT_BYTE: ld_data = {{(DATA_W-8){ld_sext & sh[7]}}, sh[7:0]};
      MT_HALF: ld_data = {{(DATA_W-16){ld_sext & sh[15]}}, sh[15:0]};
      MT_WORD: ld_data = word_ext;
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_bus.sv
// Memory-access pipeline stage: accepts a load/store from EX/MEM, runs it over a
// req/gnt/rvalid bus, stalls upstream while busy and returns aligned load data.
module mem_stage_bus
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 14,
  parameter int TIMEOUT   = 255,
  localparam int NUM_LANES = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [1:0]            mem_type,
  input  logic                  mem_sext,
  input  logic [DATA_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  stall,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_valid,
  output logic                  align_err,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [NUM_LANES-1:0]  bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int LB = $clog2(NUM_LANES);

  state_e                 state, state_nxt;
  req_ctl_t               cap_ctl;
  logic [ADDR_W-1:0]      cap_addr;
  logic [NUM_LANES-1:0]   cap_be;
  logic [DATA_W-1:0]      cap_wdata;
  logic                   cap_err;
  logic [7:0]             cnt;
  logic                   access, misalign, legal, is_idle, timed_out;
  logic [NUM_LANES-1:0]   st_be;
  logic [DATA_W-1:0]      st_wdata, ld_data;

  if (ADDR_W < DATA_W) begin : g_addr_drop
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[DATA_W-1:ADDR_W];
  end

  // Reset gates the combinational outputs too, so nothing is visible during reset.
  assign access    = reset & ex_valid & (mem_rd ^ mem_wr);
  assign is_idle   = (state == S_IDLE);
  assign legal     = access & ~misalign;
  assign align_err = is_idle & access & misalign;
  assign stall     = (is_idle & legal) | (state == S_REQ) | (state == S_WAIT);
  // A read beat in the final wait cycle still wins over the timeout.
  assign timed_out = (cnt == 8'(TIMEOUT)) & ~bus_rvalid;

  assign bus_req     = (state == S_REQ);
  assign bus_we      = bus_req & cap_ctl.we;
  assign bus_addr    = bus_req ? {cap_addr[ADDR_W-1:LB], {LB{1'b0}}} : '0;
  assign bus_be      = bus_req ? (cap_ctl.we ? cap_be : '1) : '0;
  assign bus_wdata   = bus_we ? cap_wdata : '0;
  assign rdata_valid = (state == S_DONE) & ~cap_ctl.we;
  assign bus_err     = (state == S_DONE) & cap_err;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_type      (mem_type_e'(mem_type)),
    .st_addr_lo   (addr[2:0]),
    .st_wdata     (wdata),
    .misalign     (misalign),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata),
    .ld_type      (cap_ctl.mtype),
    .ld_sext      (cap_ctl.sext),
    .ld_lane      (cap_addr[LB-1:0]),
    .ld_rdata     (bus_rdata),
    .ld_data      (ld_data)
  );

  // State register; async reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: stores are posted at grant, loads wait for data or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (legal) state_nxt = S_REQ;
      S_REQ:  if (bus_gnt) state_nxt = cap_ctl.we ? S_DONE : S_WAIT;
      S_WAIT: if (bus_rvalid || timed_out) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, timeout counter and load result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_ctl   <= '0;
      cap_addr  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
      cap_err   <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: if (legal) begin
          cap_ctl.we    <= mem_wr;
          cap_ctl.mtype <= mem_type_e'(mem_type);
          cap_ctl.sext  <= mem_sext;
          cap_addr      <= addr[ADDR_W-1:0];
          cap_be        <= st_be;
          cap_wdata     <= st_wdata;
          cap_err       <= 1'b0;
        end
        S_REQ: if (bus_gnt) cnt <= '0;
        S_WAIT: begin
          if (bus_rvalid) begin
            rdata <= ld_data;
          end else if (timed_out) begin
            rdata   <= '0;
            cap_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_bus.sv
// Scoreboard bench for mem_stage_bus, run on a 32-bit and a 64-bit instance.
module tb_mem_stage_bus;

  localparam int AW = 14;
  localparam int TO = 4;

  typedef struct packed {
    logic [63:0] ba;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wd;
  } bexp_t;

  typedef struct packed {
    logic        aerr;
    logic        rv;
    logic        berr;
    logic [63:0] rd;
  } dexp_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  bit   done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_ev(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  // Reference rules for the access, independent of any implementation detail.
  function automatic int m_size(input logic [1:0] t);
    case (t)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 8;
    endcase
  endfunction

  function automatic bit m_legal(input int dw, input logic [1:0] t, input logic [63:0] a);
    return (t == 2'b11) ? (dw == 64 && a % 8 == 0) : (a % m_size(t) == 0);
  endfunction

  function automatic logic [7:0] m_be(input int dw, input logic [1:0] t, input logic [63:0] a);
    int lane = int'(a % (dw / 8));
    return 8'(((1 << m_size(t)) - 1) << lane);
  endfunction

  function automatic logic [63:0] m_wd(input int dw, input logic [1:0] t, input logic [63:0] wd);
    logic [63:0] r = '0;
    int sz = m_size(t);
    for (int i = 0; i < dw / 8; i++) r[i*8 +: 8] = wd[(i % sz)*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_ld(input int dw, input logic [1:0] t, input logic sx,
                                       input logic [63:0] a, input logic [63:0] rp);
    int nb = m_size(t) * 8;
    logic [63:0] v = rp >> (int'(a % (dw / 8)) * 8);
    logic [63:0] msk = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    v = v & msk;
    if (sx && nb < dw && v[nb-1]) v = v | ~msk;
    return (dw == 64) ? v : (v & 64'hFFFF_FFFF);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gw
    localparam int DW = (g == 0) ? 32 : 64;
    localparam int LN = DW / 8;

    logic rst_n, ex_valid, mem_rd, mem_wr, mem_sext;
    logic [1:0] mem_type;
    logic [DW-1:0] addr, wdata, rdata, bus_wdata, bus_rdata;
    logic stall, rdata_valid, align_err, bus_err, bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [AW-1:0] bus_addr;
    logic [LN-1:0] bus_be;
    bexp_t bq[$];
    dexp_t dq[$];

    mem_stage_bus #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(rst_n), .ex_valid(ex_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_type(mem_type), .mem_sext(mem_sext), .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .align_err(align_err),
      .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
    );

    task automatic c(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("w%0d %s", DW, nm), act, exp);
    endtask

    // Issue one access; rdl > TO means the bus never returns read data.
    task automatic op(input logic rd, input logic wr, input logic [1:0] t, input logic sx,
                      input logic [63:0] a, input logic [63:0] wd, input int gd,
                      input int rdl, input logic [63:0] rp);
      bit acc, lg;
      bexp_t b;
      dexp_t d;
      int n;
      acc = rd ^ wr;
      lg  = acc && m_legal(DW, t, a);
      if (acc && !lg) begin
        d = '{aerr: 1'b1, rv: 1'b0, berr: 1'b0, rd: '0};
        dq.push_back(d);
      end else if (lg) begin
        b.ba = a[AW-1:0] & ~64'(LN - 1);
        b.we = wr;
        b.be = wr ? m_be(DW, t, a) : 8'((1 << LN) - 1);
        b.wd = wr ? m_wd(DW, t, wd) : '0;
        bq.push_back(b);
        if (rd) begin
          d.aerr = 1'b0;
          d.rv   = 1'b1;
          d.berr = (rdl > TO);
          d.rd   = (rdl > TO) ? '0 : m_ld(DW, t, sx, a, rp);
          dq.push_back(d);
        end
      end
      @(posedge clk); #1;
      ex_valid = 1'b1; mem_rd = rd; mem_wr = wr; mem_type = t; mem_sext = sx;
      addr = a[DW-1:0]; wdata = wd[DW-1:0];
      if (lg) begin
        @(posedge clk); #1;
        repeat (gd) @(posedge clk);
        #1 bus_gnt = 1'b1;
        @(posedge clk); #1 bus_gnt = 1'b0;
        if (rd && rdl <= TO) begin
          repeat (rdl) @(posedge clk);
          #1 bus_rvalid = 1'b1; bus_rdata = rp[DW-1:0];
          @(posedge clk); #1 bus_rvalid = 1'b0; bus_rdata = DW'({$urandom, $urandom});
        end
        n = 0;
        while (stall && n < TO + 20) begin
          @(posedge clk); #1;
          n++;
        end
        c("stall_release", stall, 0);
      end
      @(posedge clk); #1;
      ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    // Reset pulled in the middle of a load wait; the late beat must be ignored.
    task automatic rst_in_wait();
      bexp_t b;
      b.ba = 64'h40; b.we = 1'b0; b.be = 8'((1 << LN) - 1); b.wd = '0;
      bq.push_back(b);
      @(posedge clk); #1;
      ex_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_type = 2'b00; mem_sext = 1'b0;
      addr = DW'(64'h40);
      @(posedge clk); #1 bus_gnt = 1'b1;
      @(posedge clk); #1 bus_gnt = 1'b0;
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      c("rst_wait bus_req", bus_req, 0);
      c("rst_wait stall", stall, 0);
      c("rst_wait rdata_valid", rdata_valid, 0);
      ex_valid = 1'b0; mem_rd = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1 bus_rvalid = 1'b1; bus_rdata = DW'(64'h1234_5678_9ABC_DEF0);
      @(posedge clk); #1 bus_rvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    endtask

    // Monitor: compares bus requests and completions against the queues.
    initial begin
      bexp_t b;
      dexp_t d;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (bus_req) begin
            if (bq.size() == 0) fail_ev($sformatf("w%0d bus_req_unexpected", DW));
            else begin
              b = bq[0];
              c("bus_addr", bus_addr, b.ba);
              c("bus_we", bus_we, b.we);
              c("bus_be", bus_be, b.be);
              if (b.we) c("bus_wdata", bus_wdata, b.wd);
              c("stall_in_req", stall, 1);
              if (bus_gnt) void'(bq.pop_front());
            end
          end else begin
            c("bus_idle_zero", {bus_we, |bus_addr, |bus_be, |bus_wdata}, 0);
          end
          if (align_err || rdata_valid || bus_err) begin
            if (dq.size() == 0) fail_ev($sformatf("w%0d completion_unexpected", DW));
            else begin
              d = dq.pop_front();
              c("done_flags", {align_err, rdata_valid, bus_err, stall}, {d.aerr, d.rv, d.berr, 1'b0});
              if (rdata_valid) c("rdata", rdata, d.rd);
            end
          end
        end
      end
    end

    // Stimulus: reset check, directed cases, then randomized accesses.
    initial begin
      logic [63:0] a, wd, rp;
      logic [1:0] t;
      logic rd, wr, sx;
      int r, gd, rdl;
      rst_n = 1'b0; ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_type = 2'b00;
      mem_sext = 1'b0; addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      c("reset stall", stall, 0);
      c("reset bus_req", bus_req, 0);
      c("reset rdata_valid", rdata_valid, 0);
      c("reset align_err", align_err, 0);
      c("reset bus_err", bus_err, 0);
      c("reset rdata", rdata, 0);

      rp = 64'h80FF7F01_80FF7F01;
      op(0, 1, 2'b00, 0, 64'h1004, 64'hDEADBEEF, 2, 0, rp);
      op(1, 0, 2'b10, 1, 64'h2, 0, 0, 1, rp);
      op(1, 0, 2'b10, 0, 64'h2, 0, 0, 1, rp);
      op(1, 0, 2'b01, 1, 64'h2, 0, 1, 0, rp);
      op(0, 1, 2'b01, 0, 64'h3, 64'h55AA, 0, 0, rp);
      op(1, 0, 2'b00, 0, 64'h2, 0, 0, 0, rp);
      op(1, 0, 2'b00, 0, 64'h0, 0, 0, TO + 1, rp);
      op(1, 0, 2'b00, 1, 64'h8, 0, 0, TO, 64'hFEDC_BA98_8765_4321);
      op(0, 1, 2'b10, 0, 64'h5, 64'hAB, 0, 0, rp);
      op(1, 0, 2'b11, 0, 64'h4, 0, 0, 0, rp);
      op(1, 0, 2'b11, 0, 64'h8, 0, 1, 2, 64'h8123_4567_89AB_CDEF);
      op(0, 1, 2'b11, 0, 64'h10, 64'h0102_0304_0506_0708, 0, 0, rp);
      op(1, 1, 2'b00, 0, 64'h20, 64'h1, 0, 0, rp);
      rst_in_wait();

      for (int k = 0; k < 150; k++) begin
        r  = $urandom_range(0, 9);
        rd = (r < 4) || (r == 8);
        wr = (r >= 4 && r < 8) || (r == 8);
        t  = 2'($urandom_range(0, 3));
        sx = 1'($urandom_range(0, 1));
        a  = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) a = a & ~64'(m_size(t) - 1);
        wd = {$urandom, $urandom};
        rp = {$urandom, $urandom};
        gd = $urandom_range(0, 3);
        rdl = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO);
        op(rd, wr, t, sx, a, wd, gd, rdl, rp);
      end
      repeat (2) @(posedge clk);
      #1;
      c("bus_queue_drained", bq.size(), 0);
      c("done_queue_drained", dq.size(), 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 50000; i++) begin
      if (done[0] && done[1]) break;
      @(posedge clk);
    end
    if (!(done[0] && done[1])) fail_ev("global_cycle_budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
